// File: rtl/fft_bfu_sched.sv
// fft_bfu_sched: issues {addr_a, addr_b, tw_idx, stage} for every butterfly of an in-place radix-2 DIT FFT.
// Optional macro FFT_SCHED_DRAIN_EN inserts a BFU_LAT+1 cycle drain gap between stages.
module fft_bfu_sched #(
  parameter int LOG2N   = 3,
  parameter int BFU_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N-2:0] tw_idx,
  output logic [3:0]       stage,
  output logic             last_in_stage
);
  // state | meaning
  // IDLE  | waiting for start
  // RUN   | descriptor for (s_q, j_q) presented on the outputs
  // DRAIN | between stages, out_valid low while the bfu pipeline empties
  // DONE  | one-cycle completion pulse

  if (LOG2N < 2 || LOG2N > 15 || BFU_LAT < 0) begin : g_bad_param
    $error("fft_bfu_sched: LOG2N must be 2..15 and BFU_LAT >= 0");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
`ifdef FFT_SCHED_DRAIN_EN
    DRAIN = 2'd2,
`endif
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       s_q, s_d;
  logic [LOG2N-2:0] j_q, j_d;
  logic             j_last, s_final;

`ifdef FFT_SCHED_DRAIN_EN
  localparam int CW = $clog2(BFU_LAT + 1) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  assign j_last  = (j_q == '1);
  assign s_final = (s_q == 4'(LOG2N - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      j_q     <= '0;
`ifdef FFT_SCHED_DRAIN_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      j_q     <= j_d;
`ifdef FFT_SCHED_DRAIN_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    j_d     = j_q;
`ifdef FFT_SCHED_DRAIN_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          s_d     = '0;
          j_d     = '0;
        end
      end
      RUN: begin
        if (out_ready) begin
          if (j_last) begin
            j_d = '0;
            if (s_final) begin
              state_d = DONE;
            end else begin
              s_d = s_q + 4'd1;
`ifdef FFT_SCHED_DRAIN_EN
              state_d = DRAIN;
              cnt_d   = CW'(BFU_LAT);
`endif
            end
          end else begin
            j_d = j_q + (LOG2N-1)'(1);
          end
        end
      end
`ifdef FFT_SCHED_DRAIN_EN
      // terminal count at zero gives BFU_LAT+1 drain cycles
      DRAIN: begin
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - CW'(1);
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign out_valid = (state_q == RUN);
  assign done      = (state_q == DONE);
`ifdef FFT_SCHED_DRAIN_EN
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
`else
  assign busy      = (state_q == RUN);
`endif

  logic [LOG2N-2:0] half_m1, pos, grp;
  logic [3:0]       sh;

  // descriptor outputs are forced to zero whenever no beat is offered
  always_comb begin
    half_m1       = ~({(LOG2N-1){1'b1}} << s_q);
    pos           = j_q & half_m1;
    grp           = j_q >> s_q;
    sh            = 4'(LOG2N - 1) - s_q;
    addr_a        = '0;
    addr_b        = '0;
    tw_idx        = '0;
    stage         = '0;
    last_in_stage = 1'b0;
    if (out_valid) begin
      addr_a        = ({grp, 1'b0} << s_q) | {1'b0, pos};
      addr_b        = addr_a | (LOG2N'(1) << s_q);
      tw_idx        = pos << sh;
      stage         = s_q;
      last_in_stage = j_last;
    end
  end

endmodule

// File: tb/tb_fft_bfu_sched.sv
// Self-checking bench for fft_bfu_sched: scoreboard model of the butterfly order plus literal beat tables.
module tb_fft_bfu_sched;
  logic clk = 1'b0;
  logic rst, start, ready, start4;
  logic busy, done, vld, last;
  logic [2:0] aa, ab;
  logic [1:0] tw;
  logic [3:0] st;
  logic busy4, done4, vld4, last4;
  logic [3:0] aa4, ab4, st4;
  logic [2:0] tw4;

  fft_bfu_sched #(.LOG2N(3), .BFU_LAT(2)) dut (
    .clk(clk), .reset(rst), .start(start), .busy(busy), .done(done),
    .out_valid(vld), .out_ready(ready), .addr_a(aa), .addr_b(ab),
    .tw_idx(tw), .stage(st), .last_in_stage(last));

  fft_bfu_sched #(.LOG2N(4), .BFU_LAT(2)) dut4 (
    .clk(clk), .reset(rst), .start(start4), .busy(busy4), .done(done4),
    .out_valid(vld4), .out_ready(1'b1), .addr_a(aa4), .addr_b(ab4),
    .tw_idx(tw4), .stage(st4), .last_in_stage(last4));

  always #5 clk = ~clk;

`ifdef FFT_SCHED_DRAIN_EN
  localparam int GAP = 3;
`else
  localparam int GAP = 0;
`endif

  typedef struct { int a; int b; int tw; int s; int last; } beat_t;

  int total = 0, bad = 0, cyc = 0;
  beat_t exp_q[$], exp4_q[$], log0[$], log4[$];
  int logc0[$];
  int ndone0 = 0, ndone4 = 0, done_cyc0 = 0, start_cyc0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // k-th butterfly of an N=2^lg pass, enumerated stage by stage, group by group
  function automatic beat_t model_beat(input int lg, input int k);
    beat_t r;
    int n, cnt, half, ngrp;
    r = '{0, 0, 0, 0, 0};
    n = 1 << lg;
    cnt = 0;
    for (int s = 0; s < lg; s++) begin
      half = 1 << s;
      ngrp = n / (2 * half);
      for (int g = 0; g < ngrp; g++)
        for (int p = 0; p < half; p++) begin
          if (cnt == k) begin
            r.a = g * 2 * half + p;
            r.b = r.a + half;
            r.tw = p * (n / (2 * half));
            r.s = s;
            r.last = (g == ngrp - 1 && p == half - 1) ? 1 : 0;
          end
          cnt++;
        end
    end
    return r;
  endfunction

  // single compare process for both instances
  initial begin
    beat_t cur, held, e;
    bit hold_p;
    hold_p = 0;
    held = '{0, 0, 0, 0, 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_p = 0;
      end else begin
        cur = '{int'(aa), int'(ab), int'(tw), int'(st), int'(last)};
        if (hold_p) begin
          chk("hold_valid", int'(vld), 1);
          chk("hold_addr_a", cur.a, held.a);
          chk("hold_addr_b", cur.b, held.b);
          chk("hold_tw", cur.tw, held.tw);
          chk("hold_stage", cur.s, held.s);
        end
        if (vld) chk("busy_with_valid", int'(busy), 1);
        if (vld && ready) begin
          if (exp_q.size() == 0) chk("extra_beat", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("addr_a", cur.a, e.a);
            chk("addr_b", cur.b, e.b);
            chk("tw_idx", cur.tw, e.tw);
            chk("stage", cur.s, e.s);
            chk("last_in_stage", cur.last, e.last);
          end
          log0.push_back(cur);
          logc0.push_back(cyc);
        end
        hold_p = vld && !ready;
        held = cur;
        if (done) begin
          ndone0++;
          done_cyc0 = cyc;
          chk("done_all_beats", exp_q.size(), 0);
          chk("done_busy_low", int'(busy), 0);
        end
        if (vld4) begin
          cur = '{int'(aa4), int'(ab4), int'(tw4), int'(st4), int'(last4)};
          if (exp4_q.size() == 0) chk("extra_beat4", 1, 0);
          else begin
            e = exp4_q.pop_front();
            chk("n16_addr_a", cur.a, e.a);
            chk("n16_addr_b", cur.b, e.b);
            chk("n16_tw_idx", cur.tw, e.tw);
            chk("n16_stage", cur.s, e.s);
            chk("n16_last", cur.last, e.last);
          end
          log4.push_back(cur);
        end
        if (done4) begin
          ndone4++;
          chk("done4_all_beats", exp4_q.size(), 0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pass0();
    log0.delete();
    logc0.delete();
    exp_q.delete();
    ndone0 = 0;
    for (int k = 0; k < 12; k++) exp_q.push_back(model_beat(3, k));
    start = 1'b1;
    start_cyc0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_beats0(input int n, input int budget);
    int c = 0;
    while (log0.size() < n && c < budget) begin
      tick();
      c++;
    end
    if (log0.size() < n) chk("wait_beats_timeout", log0.size(), n);
  endtask

  task automatic wait_done0(input int budget);
    int c = 0;
    while (ndone0 == 0 && c < budget) begin
      tick();
      c++;
    end
    if (ndone0 == 0) chk("wait_done_timeout", 0, 1);
  endtask

  int t1a[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int t1b[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int t1t[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  initial begin
    int seen[16];
    int c;
    rst = 1'b1; start = 1'b0; ready = 1'b1; start4 = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_valid", int'(vld), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_addr_a", int'(aa), 0);
    chk("rst_addr_b", int'(ab), 0);
    chk("rst_tw", int'(tw), 0);
    chk("rst_stage", int'(st), 0);
    chk("rst_last", int'(last), 0);
    tick();
    rst = 1'b0;
    tick();

    // 1: straight pass, literal beat table and timing
    start_pass0();
    wait_done0(60);
    chk("t1_beats", log0.size(), 12);
    if (log0.size() == 12) begin
      for (int i = 0; i < 12; i++) begin
        chk("t1_lit_a", log0[i].a, t1a[i]);
        chk("t1_lit_b", log0[i].b, t1b[i]);
        chk("t1_lit_tw", log0[i].tw, t1t[i]);
        chk("t1_lit_stage", log0[i].s, i / 4);
        chk("t1_lit_last", log0[i].last, (i % 4 == 3) ? 1 : 0);
        chk("t1_beat_cycle", logc0[i] - logc0[0], i + GAP * (i / 4));
      end
      chk("t1_first_latency", logc0[0] - start_cyc0, 1);
      chk("t1_done_cycle", done_cyc0, logc0[11] + 1);
    end
    tick();
    @(negedge clk);
    chk("t1_idle_busy", int'(busy), 0);
    chk("t1_idle_done", int'(done), 0);
    chk("t1_idle_valid", int'(vld), 0);
    tick();

    // 2: backpressure on beat 2
    start_pass0();
    wait_beats0(1, 10);
    ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t2_valid", int'(vld), 1);
      chk("t2_a", int'(aa), 2);
      chk("t2_b", int'(ab), 3);
      chk("t2_tw", int'(tw), 0);
      chk("t2_stage", int'(st), 0);
    end
    tick();
    ready = 1'b1;
    wait_done0(60);
    chk("t2_beats", log0.size(), 12);
    if (log0.size() >= 3) begin
      chk("t2_beat3_a", log0[2].a, 4);
      chk("t2_beat3_b", log0[2].b, 5);
    end
    tick();

    // 3: start pulses mid-pass and during done are ignored
    start_pass0();
    wait_beats0(6, 30);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_beats0(12, 40);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("t3_beats", log0.size(), 12);
    chk("t3_done_count", ndone0, 1);
    @(negedge clk);
    chk("t3_busy_after", int'(busy), 0);
    chk("t3_valid_after", int'(vld), 0);
    tick();

    // 4: reset mid-pass aborts, fresh start restarts at s=0 j=0
    start_pass0();
    wait_beats0(5, 30);
    rst = 1'b1;
    ready = 1'b0;
    exp_q.delete();
    tick();
    @(negedge clk);
    chk("t4_valid", int'(vld), 0);
    chk("t4_busy", int'(busy), 0);
    chk("t4_done", int'(done), 0);
    chk("t4_addr_a", int'(aa), 0);
    chk("t4_addr_b", int'(ab), 0);
    chk("t4_stage", int'(st), 0);
    chk("t4_no_done", ndone0, 0);
    tick();
    rst = 1'b0;
    ready = 1'b1;
    tick();
    start_pass0();
    wait_beats0(1, 10);
    if (log0.size() >= 1) begin
      chk("t4_first_a", log0[0].a, 0);
      chk("t4_first_b", log0[0].b, 1);
      chk("t4_first_tw", log0[0].tw, 0);
      chk("t4_first_stage", log0[0].s, 0);
    end
    wait_done0(60);
    chk("t4_beats", log0.size(), 12);
    tick();

    // 6: N=16 sweep
    log4.delete();
    exp4_q.delete();
    for (int k = 0; k < 32; k++) exp4_q.push_back(model_beat(4, k));
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    c = 0;
    while (ndone4 == 0 && c < 120) begin
      tick();
      c++;
    end
    chk("t6_done", ndone4, 1);
    chk("t6_beats", log4.size(), 32);
    if (log4.size() == 32) begin
      for (int s = 0; s < 4; s++) begin
        for (int i = 0; i < 16; i++) seen[i] = 0;
        for (int i = 0; i < 8; i++) begin
          seen[log4[s * 8 + i].a]++;
          seen[log4[s * 8 + i].b]++;
          chk("t6_span", log4[s * 8 + i].b - log4[s * 8 + i].a, 1 << s);
        end
        c = 0;
        for (int i = 0; i < 16; i++) if (seen[i] == 1) c++;
        chk("t6_cover", c, 16);
      end
      for (int i = 0; i < 8; i++) chk("t6_s3_tw", log4[24 + i].tw, i);
    end
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
